// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage external data bus controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_bus_pkg;

    // Bus controller FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } busState_t;

    // MB_inSIZE / SIZE access-size codes; 2'b11 is illegal
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Default BUSY cycles tolerated without ACKD_n before an access is aborted
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // Request fields latched in IDLE and replayed onto the bus during BUSY
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } busReq_t;

endpackage

// File: rtl/mem_align_chk.sv
// Legality check of an access: flags illegal size codes and misaligned half/word addresses.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   addrLsb  in  2  low two bits of the byte address
//   size     in  2  access size code (SZ_BYTE / SZ_HALF / SZ_WORD)
//   illegal  out 1  high when the access must not reach the bus
module mem_align_chk
    import mem_bus_pkg::*;
(
    input  logic [1:0] addrLsb,
    input  logic [1:0] size,
    output logic       illegal
);

    always_comb begin
        case (size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = addrLsb[0];
            SZ_WORD: illegal = |addrLsb;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage bridge from pipeline load/store requests to a single external data bus.
// Latency: request in cycle 0, MREQ from cycle 1, DONE the cycle after ACKD_n low (minimum 3 cycles).
// Backpressure: MB_outSTALL holds the pipeline from request acceptance until DONE; the bus waits on ACKD_n.
//
// Optional feature: define MEMBUS_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles with no ACKD_n.
//
// Ports:
//   CLOCK, RESET                  clock, async active-low reset
//   MB_inMEMREAD/MB_inMEMWRITE    load/store request (both high = store)
//   MB_inADDR/MB_inWDATA/MB_inSIZE request address, store data, size code
//   MB_outRDATA/MB_outRVALID      load data (held) and one-cycle completion pulse
//   MB_outSTALL                   pipeline freeze
//   MB_outERR                     one-cycle error pulse (illegal or timed-out access)
//   DAD/DDT/MREQ/WRITE/SIZE/ACKD_n external bus: address, data, request, direction, size, ack
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        MB_inMEMREAD,
    input  logic        MB_inMEMWRITE,
    input  logic [31:0] MB_inADDR,
    input  logic [31:0] MB_inWDATA,
    input  logic [1:0]  MB_inSIZE,
    output logic [31:0] MB_outRDATA,
    output logic        MB_outRVALID,
    output logic        MB_outSTALL,
    output logic        MB_outERR,
    output logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    busState_t state;
    busState_t stateNext;
    busReq_t   req;

    logic request;
    logic illegal;
    logic ackSeen;
    logic timeoutHit;

    // Strobes produced by the output process and consumed by the datapath registers
    logic loadReq;
    logic endBusy;
    logic captureRead;
    logic setErr;

    assign request = MB_inMEMREAD | MB_inMEMWRITE;
    assign ackSeen = ~ACKD_n;

    mem_align_chk uAlignChk (
        .addrLsb (MB_inADDR[1:0]),
        .size    (MB_inSIZE),
        .illegal (illegal)
    );

    // State register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; DONE never re-samples the request because the pipeline
    // only advances at the end of DONE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (request) begin
                    stateNext = illegal ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (ackSeen || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: stall plus datapath strobes. An ack in the final timeout
    // cycle still completes the access normally.
    always_comb begin
        MB_outSTALL = 1'b0;
        loadReq     = 1'b0;
        endBusy     = 1'b0;
        captureRead = 1'b0;
        setErr      = 1'b0;
        case (state)
            IDLE: begin
                MB_outSTALL = request;
                loadReq     = request & ~illegal;
                setErr      = request & illegal;
            end
            BUSY: begin
                MB_outSTALL = 1'b1;
                endBusy     = ackSeen | timeoutHit;
                captureRead = ackSeen & ~WRITE;
                setErr      = ~ackSeen & timeoutHit;
            end
            default: ;
        endcase
    end

    // Bus-facing controls are flops so MREQ/WRITE/SIZE only move on clock edges.
    // WRITE doubles as the DDT output enable and is therefore only high in BUSY.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            req          <= '0;
            MREQ         <= 1'b0;
            WRITE        <= 1'b0;
            MB_outRDATA  <= '0;
            MB_outRVALID <= 1'b0;
            MB_outERR    <= 1'b0;
        end else begin
            MB_outRVALID <= captureRead;
            MB_outERR    <= setErr;
            if (captureRead) begin
                MB_outRDATA <= DDT;
            end
            if (loadReq) begin
                req.addr  <= MB_inADDR;
                req.wdata <= MB_inWDATA;
                req.size  <= MB_inSIZE;
                MREQ      <= 1'b1;
                WRITE     <= MB_inMEMWRITE;
            end else if (endBusy) begin
                MREQ  <= 1'b0;
                WRITE <= 1'b0;
            end
        end
    end

    assign DAD  = req.addr;
    assign SIZE = req.size;
    assign DDT  = WRITE ? req.wdata : 'z;

`ifdef MEMBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] toCount;

    // Counts BUSY cycles already spent; the last allowed cycle is TIMEOUT_CYCLES-1
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            toCount <= '0;
        end else if (loadReq) begin
            toCount <= '0;
        end else if (state == BUSY) begin
            toCount <= toCount + CNT_W'(1);
        end
    end

    assign timeoutHit = (state == BUSY) && (toCount == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: transaction-level timeline model plus per-cycle compare.
// Latency: n/a.
// Backpressure: bench answers the bus with ACKD_n after a chosen number of BUSY cycles.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int TB_TIMEOUT = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        MB_inMEMREAD = 1'b0;
    logic        MB_inMEMWRITE = 1'b0;
    logic [31:0] MB_inADDR = '0;
    logic [31:0] MB_inWDATA = '0;
    logic [1:0]  MB_inSIZE = '0;
    logic [31:0] MB_outRDATA;
    logic        MB_outRVALID;
    logic        MB_outSTALL;
    logic        MB_outERR;
    logic [31:0] DAD;
    tri1  [31:0] DDT;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n = 1'b1;

    // Bench-side read-data driver; a released bus floats to all ones via tri1
    logic        tbDrv = 1'b0;
    logic [31:0] tbData = '0;
    assign DDT = tbDrv ? tbData : 'z;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .MB_inMEMREAD  (MB_inMEMREAD),
        .MB_inMEMWRITE (MB_inMEMWRITE),
        .MB_inADDR     (MB_inADDR),
        .MB_inWDATA    (MB_inWDATA),
        .MB_inSIZE     (MB_inSIZE),
        .MB_outRDATA   (MB_outRDATA),
        .MB_outRVALID  (MB_outRVALID),
        .MB_outSTALL   (MB_outSTALL),
        .MB_outERR     (MB_outERR),
        .DAD           (DAD),
        .DDT           (DDT),
        .MREQ          (MREQ),
        .WRITE         (WRITE),
        .SIZE          (SIZE),
        .ACKD_n        (ACKD_n)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    bit          chkEn = 1'b0;
    bit          expStall, expMreq, expRvalid, expErr, expBusy, expWrite;
    logic [31:0] expDad, expWdata, expRdata;
    logic [1:0]  expSize;

    // Per-transaction observation counters
    int stallCnt, mreqCnt, rvCnt, errCnt, wrCnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic setIdleExp(input bit stall);
        expStall  = stall;
        expMreq   = 1'b0;
        expRvalid = 1'b0;
        expErr    = 1'b0;
        expBusy   = 1'b0;
        expWrite  = 1'b0;
    endtask

    task automatic clrCnt();
        stallCnt = 0; mreqCnt = 0; rvCnt = 0; errCnt = 0; wrCnt = 0;
    endtask

    // Per-cycle compare against the model's expectations
    always @(negedge CLOCK) begin
        if (chkEn) begin
            check("STALL",  32'(MB_outSTALL),  32'(expStall));
            check("MREQ",   32'(MREQ),         32'(expMreq));
            check("RVALID", 32'(MB_outRVALID), 32'(expRvalid));
            check("ERR",    32'(MB_outERR),    32'(expErr));
            check("RDATA",  MB_outRDATA,       expRdata);
            if (expBusy) begin
                check("DAD",   DAD,          expDad);
                check("WRITE", 32'(WRITE),   32'(expWrite));
                check("SIZE",  32'(SIZE),    32'(expSize));
            end
            if (expBusy && expWrite) begin
                check("DDT drive", DDT, expWdata);
            end else if (!tbDrv) begin
                check("DDT release", DDT, 32'hFFFF_FFFF);
            end
            stallCnt += int'(MB_outSTALL);
            mreqCnt  += int'(MREQ);
            rvCnt    += int'(MB_outRVALID);
            errCnt   += int'(MB_outERR);
            wrCnt    += int'(WRITE);
        end
    end

    // One access from request to DONE. Model: illegal -> straight to DONE with ERR;
    // legal -> BUSY until the ack cycle (or timeout), then DONE with RVALID for reads.
    // Returns at the start of the cycle after DONE with the request still applied.
    task automatic runTxn(input bit rd, input bit wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] rdat);
        bit wrOp;
        bit rdOp;
        bit bad;
        bit timedOut;
        int busyLen;
        wrOp     = wr;
        rdOp     = rd && !wr;
        bad      = (sz == 2'd3) || ((addr % (32'd1 << sz)) != 0);
        busyLen  = delay + 1;
        timedOut = 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
        if (busyLen > TB_TIMEOUT) begin
            busyLen  = TB_TIMEOUT;
            timedOut = 1'b1;
        end
`endif
        MB_inMEMREAD  = rd;
        MB_inMEMWRITE = wr;
        MB_inADDR     = addr;
        MB_inWDATA    = wdata;
        MB_inSIZE     = sz;
        setIdleExp(1'b1);
        @(posedge CLOCK); #1;
        if (!bad) begin
            for (int j = 1; j <= busyLen; j++) begin
                expStall = 1'b1; expMreq = 1'b1; expRvalid = 1'b0; expErr = 1'b0;
                expBusy  = 1'b1; expWrite = wrOp; expDad = addr; expSize = sz; expWdata = wdata;
                if (!timedOut && j == busyLen) begin
                    ACKD_n = 1'b0;
                    if (rdOp) begin
                        tbData = rdat;
                        tbDrv  = 1'b1;
                    end
                end
                @(posedge CLOCK); #1;
                ACKD_n = 1'b1;
                tbDrv  = 1'b0;
            end
        end
        expBusy   = 1'b0;
        expWrite  = 1'b0;
        expStall  = 1'b0;
        expMreq   = 1'b0;
        expRvalid = rdOp && !bad && !timedOut;
        expErr    = bad || timedOut;
        if (expRvalid) expRdata = rdat;
        @(posedge CLOCK); #1;
    endtask

    task automatic idleCycles(input int n, input bit noise);
        MB_inMEMREAD  = 1'b0;
        MB_inMEMWRITE = 1'b0;
        setIdleExp(1'b0);
        for (int i = 0; i < n; i++) begin
            ACKD_n = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLOCK); #1;
        end
        ACKD_n = 1'b1;
    endtask

    int          op;
    bit          rRd, rWr;
    logic [1:0]  rSz;
    logic [31:0] rAddr, rWdata, rRdat;
    int          rDelay;

    initial begin
        expRdata = '0;
        setIdleExp(1'b0);
        clrCnt();

        // Reset state, before any clock edge
        #2;
        check("reset MREQ",   32'(MREQ),         32'd0);
        check("reset WRITE",  32'(WRITE),        32'd0);
        check("reset SIZE",   32'(SIZE),         32'd0);
        check("reset DAD",    DAD,               32'd0);
        check("reset DDT",    DDT,               32'hFFFF_FFFF);
        check("reset RDATA",  MB_outRDATA,       32'd0);
        check("reset RVALID", 32'(MB_outRVALID), 32'd0);
        check("reset ERR",    32'(MB_outERR),    32'd0);
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        chkEn = 1'b1;
        idleCycles(2, 1'b0);

        // Word read, ack two cycles after MREQ rises
        clrCnt();
        runTxn(1'b1, 1'b0, SZ_WORD, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
        check("word read stall cycles", 32'(stallCnt), 32'd4);
        check("word read mreq cycles",  32'(mreqCnt),  32'd3);
        check("word read rvalid count", 32'(rvCnt),    32'd1);
        check("word read rdata",        MB_outRDATA,   32'hDEAD_BEEF);
        idleCycles(1, 1'b0);

        // Byte write, immediate ack
        clrCnt();
        runTxn(1'b0, 1'b1, SZ_BYTE, 32'h0000_0203, 32'h0000_00A5, 0, 32'h0);
        check("byte write stall cycles", 32'(stallCnt), 32'd2);
        check("byte write mreq cycles",  32'(mreqCnt),  32'd1);
        check("byte write write cycles", 32'(wrCnt),    32'd1);
        check("byte write rvalid count", 32'(rvCnt),    32'd0);

        // Misaligned half read, back to back
        clrCnt();
        runTxn(1'b1, 1'b0, SZ_HALF, 32'h0000_0101, 32'h0, 0, 32'h0);
        check("misaligned stall cycles", 32'(stallCnt), 32'd1);
        check("misaligned mreq cycles",  32'(mreqCnt),  32'd0);
        check("misaligned err count",    32'(errCnt),   32'd1);
        check("misaligned rvalid count", 32'(rvCnt),    32'd0);

        // Read and write together is a write
        clrCnt();
        runTxn(1'b1, 1'b1, SZ_WORD, 32'h0000_0010, 32'h0BAD_F00D, 1, 32'h1111_1111);
        check("rd+wr write cycles",  32'(wrCnt),  32'd2);
        check("rd+wr rvalid count",  32'(rvCnt),  32'd0);
        check("rd+wr rdata held",    MB_outRDATA, 32'hDEAD_BEEF);

`ifdef MEMBUS_TIMEOUT_EN
        // Ack never arrives: abort after TB_TIMEOUT BUSY cycles
        clrCnt();
        runTxn(1'b1, 1'b0, SZ_WORD, 32'h0000_0040, 32'h0, 20, 32'h2222_2222);
        check("timeout mreq cycles",  32'(mreqCnt),  32'd4);
        check("timeout err count",    32'(errCnt),   32'd1);
        check("timeout rvalid count", 32'(rvCnt),    32'd0);
        check("timeout rdata held",   MB_outRDATA,   32'hDEAD_BEEF);
`endif

        // Reset in the middle of a write's BUSY phase
        idleCycles(1, 1'b0);
        MB_inMEMWRITE = 1'b1;
        MB_inADDR     = 32'h0000_0300;
        MB_inWDATA    = 32'h1234_5678;
        MB_inSIZE     = SZ_WORD;
        setIdleExp(1'b1);
        @(posedge CLOCK); #1;
        expStall = 1'b1; expMreq = 1'b1; expBusy = 1'b1; expWrite = 1'b1;
        expDad = 32'h0000_0300; expSize = SZ_WORD; expWdata = 32'h1234_5678;
        @(posedge CLOCK); #3;
        chkEn = 1'b0;
        RESET = 1'b0;
        #1;
        check("async reset MREQ",   32'(MREQ),         32'd0);
        check("async reset WRITE",  32'(WRITE),        32'd0);
        check("async reset DDT",    DDT,               32'hFFFF_FFFF);
        check("async reset DAD",    DAD,               32'd0);
        check("async reset RDATA",  MB_outRDATA,       32'd0);
        check("async reset RVALID", 32'(MB_outRVALID), 32'd0);
        check("async reset ERR",    32'(MB_outERR),    32'd0);
        expRdata = '0;
        MB_inMEMWRITE = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        setIdleExp(1'b0);
        chkEn = 1'b1;
        clrCnt();
        ACKD_n = 1'b0;
        @(posedge CLOCK); #1;
        @(posedge CLOCK); #1;
        ACKD_n = 1'b1;
        @(posedge CLOCK); #1;
        check("late ack rvalid count", 32'(rvCnt),   32'd0);
        check("late ack err count",    32'(errCnt),  32'd0);
        check("late ack mreq cycles",  32'(mreqCnt), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            op     = int'($urandom_range(0, 9));
            rRd    = (op < 5) || (op == 9);
            rWr    = (op >= 5);
            rSz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rAddr  = $urandom;
            if ($urandom_range(0, 3) != 0) rAddr = rAddr & ~((32'd1 << rSz) - 32'd1);
            rWdata = $urandom;
            if (rWdata == 32'hFFFF_FFFF) rWdata = 32'h0;
            rDelay = int'($urandom_range(0, 6));
            rRdat  = $urandom;
            runTxn(rRd, rWr, rSz, rAddr, rWdata, rDelay, rRdat);
            if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 3)), 1'b1);
        end
        idleCycles(2, 1'b0);

        chkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: BUSY cycles allowed without ACKD_n before abort; used only when MEMBUS_TIMEOUT_EN is defined.
REQ-002 Port CLOCK  input  1  single clock; all state updates on rising edge.
REQ-003 Port RESET  input  1  asynchronous, active-low reset.
REQ-004 Port MB_inMEMREAD  input  1  MEM-stage load request.
REQ-005 Port MB_inMEMWRITE  input  1  MEM-stage store request.
REQ-006 Port MB_inADDR  input  32  byte address from EX/MEM ALU result.
REQ-007 Port MB_inWDATA  input  32  store data.
REQ-008 Port MB_inSIZE  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 Port MB_outRDATA  output  32  captured load data, valid while MB_outRVALID=1.
REQ-010 Port MB_outRVALID  output  1  one-cycle pulse when a load completes.
REQ-011 Port MB_outSTALL  output  1  freezes PC, IF/ID, ID/EX, EX/MEM when high.
REQ-012 Port MB_outERR  output  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-013 Ports DAD out 32, DDT inout 32, MREQ out 1, WRITE out 1, SIZE out 2, ACKD_n in 1: external data bus.

Function
REQ-014 States: IDLE, BUSY, DONE; encoding 2 bits.
REQ-015 Request = MB_inMEMREAD | MB_inMEMWRITE; if both are high, the access is a write.
REQ-016 MB_outSTALL = (IDLE & request) | BUSY, combinational; low in DONE.
REQ-017 IDLE with a legal request: register address, data, size and direction; go to BUSY.
REQ-018 IDLE with an illegal request (SIZE=11, half with ADDR[0]=1, word with ADDR[1:0]!=0): no bus cycle; go to DONE with ERR pending.
REQ-019 BUSY behaviour:
- MREQ=1.
- DAD, WRITE and SIZE are driven from registers.
- DDT is driven with the registered write data only when WRITE=1; otherwise DDT is high-Z.
REQ-020 BUSY: ACKD_n sampled low at an edge: for a read, capture DDT into MB_outRDATA on that edge; go to DONE.
REQ-021 DONE lasts one cycle:
- MREQ=0, DDT high-Z.
- RVALID=1 if the completed access was a successful read.
- ERR=1 if an error is pending.
- Next state is always IDLE; the request is not re-sampled in DONE, since the pipeline advances at the end of DONE.
REQ-022 Latency: request seen in cycle 0; MREQ high from cycle 1; ACKD_n low at cycle k; DONE in cycle k+1. Minimum is 3 cycles including DONE.
REQ-023 MB_outRDATA holds its last value until the next successful read.
REQ-024 MREQ, WRITE and SIZE change only on clock edges (glitch-free).

Reset
REQ-025 RESET low forces, immediately and without waiting for a clock edge:
- state IDLE;
- MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z;
- MB_outRDATA=0, MB_outRVALID=0, MB_outERR=0, timeout counter=0.
REQ-026 Reset during BUSY aborts the transaction; an ACKD_n arriving after release is ignored in IDLE.

Configuration
REQ-027 Macro MEMBUS_TIMEOUT_EN defined: the counter clears on entry to BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES without ACKD_n low:
- drop MREQ and go to DONE;
- ERR=1, RVALID=0, MB_outRDATA unchanged.
REQ-028 Macro MEMBUS_TIMEOUT_EN not defined: no counter logic; BUSY waits indefinitely; ERR originates only from REQ-018.

Structure
REQ-029 Shared package mem_bus_pkg holds the state enum, SIZE codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the TIMEOUT_CYCLES default.
REQ-030 One sub-module, mem_align_chk: combinational legality check of ADDR[1:0] and SIZE, output illegal flag.

Verification
REQ-031 Word read, ADDR=0x00000100, ACKD_n low 2 cycles after MREQ rises, DDT=0xDEADBEEF:
- STALL high cycles 0-3;
- RVALID and RDATA=0xDEADBEEF in DONE;
- MREQ low in DONE.
REQ-032 Byte write, ADDR=0x00000203, WDATA=0x000000A5, immediate ACK:
- DDT=0x000000A5, WRITE=1, SIZE=00 during BUSY;
- DDT high-Z in DONE;
- no RVALID.
REQ-033 Half read, ADDR=0x00000101: no MREQ; DONE next cycle with ERR=1; STALL high only in cycle 0.
REQ-034 With MEMBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, word read with ACKD_n held high: MREQ high exactly 4 cycles, then DONE with ERR=1 and RDATA unchanged.
REQ-035 Reset asserted during BUSY of a write: MREQ=0 and DDT high-Z immediately; after release, state IDLE and a late ACKD_n produces no RVALID or ERR.
REQ-036 MEMREAD and MEMWRITE both high, ADDR=0x00000010: bus cycle has WRITE=1; RVALID stays 0.
